pixel_framebuffer: RTL
======================

# pixel_framebuffer

Receiving end of the plot interface driven by the drawing datapaths (circle, line and fill engines). Stores each plotted pixel in a 160x120, 3-bit-per-pixel frame store. A raster scanner reads the frame back out in row-major order over a valid/ready pixel stream for the display or a checker. It sits between the drawing FSMs and the screen output, in the same role as the VGA adapter's write port.

## Interface
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows per frame
- CW, 3, colour bits per pixel
- CLOCK_50  in  1  system clock; all activity on the rising edge
- resetn  in  1  synchronous reset, active-low
- x  in  8  plot column
- y  in  7  plot row
- colour  in  3  plot colour
- plot  in  1  write strobe; one pixel per cycle when high
- scan_start  in  1  pulse; begins one full-frame readout
- pix_ready  in  1  downstream accepts pixel
- pix_valid  out  1  pix_* fields valid
- pix_colour  out  3  pixel colour
- pix_x  out  8  column of the presented pixel
- pix_y  out  7  row of the presented pixel
- pix_sof  out  1  high with pixel (0,0)
- pix_eol  out  1  high with x = WIDTH-1
- pix_eof  out  1  high with pixel (WIDTH-1, HEIGHT-1)
- init_done  out  1  frame store cleared; plots and scans accepted
- scan_busy  out  1  readout in progress
- oob  out  1  sticky; an out-of-range plot was dropped

## Operation
- The frame store is 19200 words x CW bits with a synchronous read. Address = y*WIDTH + x, with the arithmetic done 15 bits wide.
- The FSM has three states: CLEAR, IDLE, SCAN. Reset forces CLEAR.
- CLEAR:
  - writes 0 to addresses 0..19199, one per cycle, using a 15-bit clear counter.
  - plot and scan_start are ignored and not queued.
  - after address 19199 is written: go to IDLE and set init_done = 1.
- Plot write, in IDLE or SCAN:
  - if plot = 1, x < WIDTH and y < HEIGHT: mem[addr] <= colour on that edge.
  - if plot = 1 and the coordinate is out of range: no write; oob is set to 1 and held until reset.
- IDLE: scan_start = 1 moves to SCAN and zeroes the scan counters (sx, sy).
- SCAN:
  - read addresses are issued in row-major order.
  - the output stage holds at most one pixel plus one in-flight read, so the read-latency skid is absorbed.
  - a pixel transfers on a cycle where pix_valid && pix_ready.
  - after the transfer carrying pix_eof: go to IDLE; scan_busy falls on the next cycle.
- scan_start is ignored in SCAN and CLEAR.
- Scan order: sx counts 0..159; at 159 it wraps to 0 and sy increments. sy stops at 119.
- Each of the 19200 pixels is presented exactly once per scan. pix_sof and pix_eof each assert exactly once.
- Read/write collision on the same address in the same cycle: the read returns the old data. The write is visible to any read issued on a later cycle.
- Reset mid-scan or mid-clear: the next cycle has pix_valid = 0, scan_busy = 0, init_done = 0 and oob = 0, and the clear restarts from address 0. Frame contents are not otherwise guaranteed.
- Reset values: pix_valid 0, pix_colour/x/y 0, pix_sof/eol/eof 0, init_done 0, scan_busy 0, oob 0.

## Timing
- Clear takes 19200 cycles after resetn returns high. init_done is high on cycle 19201.
- Plot-to-store latency is 1 cycle: a pixel plotted at edge N is readable by a read issued at edge N+1.
- scan_start sampled at edge N: scan_busy = 1 after edge N; the first pix_valid (pixel 0,0) is high after edge N+2.
- With pix_ready held at 1, one pixel transfers per cycle, and a full scan takes 19200 + 2 cycles.
- Backpressure:
  - with pix_ready = 0, all pix_* outputs are held stable.
  - pix_valid never drops without a transfer.
  - no pixel is skipped or duplicated.
- pix_sof, pix_eol and pix_eof are qualified by pix_valid and change only with the pixel they describe.

## Test plan
- Reset, then wait for init_done; count cycles (must be 19200), then scan with pix_ready = 1 -> 19200 pixels, all colour 0, one sof at (0,0), 120 eol, one eof at (159,119).
- Plot (80,60) colour 5 and (0,0) colour 7, then scan -> pixel index 9680 = 5, index 0 = 7, all others 0; pix_x/pix_y match the index.
- Plot (160,0) colour 3 and (0,120) colour 3 -> oob = 1 and stays 1; a scan shows no non-zero pixel; oob clears only on reset.
- Scan with pix_ready random (50%) -> outputs stable while stalled, exactly 19200 transfers, sequence identical to the ready = 1 run.
- During a scan, plot colour 6 at (10,0) on the cycle its read is issued -> that scan returns the old value; the next scan returns 6.
- Assert resetn = 0 for one cycle at pixel 5000 of a scan -> next cycle pix_valid = 0 and scan_busy = 0; clear reruns for 19200 cycles; the following scan is all zeros.

Source files
------------

// File: rtl/pixel_framebuffer.sv
// 160x120x3 frame store fed by the drawing engines' plot port, with a
// valid/ready raster scanner that reads the whole frame out in row-major order.
module pixel_framebuffer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned CW     = 3
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    input  logic [CW-1:0] colour,
    input  logic          plot,
    input  logic          scan_start,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [CW-1:0] pix_colour,
    output logic [7:0]    pix_x,
    output logic [6:0]    pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic          init_done,
    output logic          scan_busy,
    output logic          oob
);

    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 7;
    localparam int unsigned AW    = 15;
    localparam int unsigned DEPTH = WIDTH * HEIGHT;

    localparam logic [XW-1:0] X_LIM  = XW'(WIDTH);
    localparam logic [YW-1:0] Y_LIM  = YW'(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] mem [DEPTH];

    logic [AW-1:0] clr_cnt_q;
    logic [XW-1:0] sx_q;
    logic [YW-1:0] sy_q;
    logic          rd_done_q;
    logic          rd_valid_q;
    logic [CW-1:0] rd_data_q;
    logic [XW-1:0] rd_x_q;
    logic [YW-1:0] rd_y_q;

    logic          in_range_c;
    logic [AW-1:0] plot_addr_c;
    logic [AW-1:0] rd_addr_c;
    logic          clr_last_c;
    logic          pix_fire_c;
    logic          move_c;
    logic          eof_fire_c;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [CW-1:0] mem_wdata_c;
    logic          rd_en_c;
    logic          scan_init_c;
    logic          oob_hit_c;

    assign in_range_c  = (x < X_LIM) && (y < Y_LIM);
    assign plot_addr_c = AW'(y) * AW'(WIDTH) + AW'(x);
    assign rd_addr_c   = AW'(sy_q) * AW'(WIDTH) + AW'(sx_q);
    assign clr_last_c  = (clr_cnt_q == A_LAST);
    assign pix_fire_c  = pix_valid && pix_ready;
    assign eof_fire_c  = pix_fire_c && pix_eof;
    // The fetched pixel advances whenever the output slot is empty or draining.
    assign move_c      = rd_valid_q && (!pix_valid || pix_ready);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: if (clr_last_c) state_d = ST_IDLE;
            ST_IDLE:  if (scan_start) state_d = ST_SCAN;
            ST_SCAN:  if (eof_fire_c) state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = plot_addr_c;
        mem_wdata_c = colour;
        rd_en_c     = 1'b0;
        scan_init_c = 1'b0;
        oob_hit_c   = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt_q;
                mem_wdata_c = '0;
            end
            ST_IDLE: begin
                mem_we_c    = plot && in_range_c;
                oob_hit_c   = plot && !in_range_c;
                scan_init_c = scan_start;
            end
            ST_SCAN: begin
                mem_we_c  = plot && in_range_c;
                oob_hit_c = plot && !in_range_c;
                // Only fetch when the skid register will have room after this edge.
                rd_en_c   = !rd_done_q && (!rd_valid_q || move_c);
            end
            default: ;
        endcase
    end

    // Single-port-per-direction store; a same-address read returns the old word.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
        if (rd_en_c)  rd_data_q <= mem[rd_addr_c];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clr_cnt_q  <= '0;
            init_done  <= 1'b0;
            oob        <= 1'b0;
            scan_busy  <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
        end else begin
            if (state_q == ST_CLEAR && !clr_last_c) clr_cnt_q <= clr_cnt_q + AW'(1);
            init_done <= (state_d != ST_CLEAR);
            scan_busy <= (state_d == ST_SCAN);
            if (oob_hit_c) oob <= 1'b1;

            if (scan_init_c) begin
                sx_q      <= '0;
                sy_q      <= '0;
                rd_done_q <= 1'b0;
            end else if (rd_en_c) begin
                if (sx_q == X_LAST) begin
                    sx_q <= '0;
                    if (sy_q == Y_LAST) rd_done_q <= 1'b1;
                    else                sy_q      <= sy_q + YW'(1);
                end else begin
                    sx_q <= sx_q + XW'(1);
                end
            end

            if (rd_en_c) begin
                rd_valid_q <= 1'b1;
                rd_x_q     <= sx_q;
                rd_y_q     <= sy_q;
            end else if (move_c) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // Output register: loads a new pixel only when the previous one is gone.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            pix_valid  <= 1'b0;
            pix_colour <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_eof    <= 1'b0;
        end else if (move_c) begin
            pix_valid  <= 1'b1;
            pix_colour <= rd_data_q;
            pix_x      <= rd_x_q;
            pix_y      <= rd_y_q;
            pix_sof    <= (rd_x_q == '0) && (rd_y_q == '0);
            pix_eol    <= (rd_x_q == X_LAST);
            pix_eof    <= (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);
        end else if (pix_fire_c) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
        end
    end

endmodule
